dff_bist_ctrl: RTL



---
 rtl/dff_bist_pkg.sv | 22 ++
 rtl/bist_sync2.sv | 18 +
 rtl/dff_bist_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/dff_bist_pkg.sv
// dff_bist_pkg: state encoding and fixed stimulus table for the single-flop BIST sequencer
package dff_bist_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK, DONE} state_t;
    typedef struct packed {
        logic d;
        logic r_setup;
        logic r_pulse;
        logic c_pulse;
        logic expect_q;
    } step_vec_t;
    localparam int NUM_STEPS = 8;
    localparam step_vec_t STEP_TABLE [NUM_STEPS] = '{
        '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1},
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1},
        '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0}
    };
endpackage

// File: rtl/bist_sync2.sv
// bist_sync2: two-flop synchroniser for the asynchronous Q of the flop under test
module bist_sync2 (
    input  logic C,
    input  logic R,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/dff_bist_ctrl.sv
// dff_bist_ctrl: steps a NAND-built async-reset flop through a fixed vector table and reports pass/fail
module dff_bist_ctrl
    import dff_bist_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int PULSE_W = 3,
    parameter int CNT_W   = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic             start,
    input  logic             dut_q,
    output logic             dut_d,
    output logic             dut_c,
    output logic             dut_r,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [2:0]       first_fail,
    output logic [2:0]       step
);
    localparam int PH_W = $clog2(SETTLE > PULSE_W ? SETTLE : PULSE_W);

    if (SETTLE < 3) begin : g_settle_chk
        $error("SETTLE must be at least 3 so the synchronised Q reflects the post-pulse value");
    end

    state_t          state, state_nx;
    logic [PH_W-1:0] ph;
    logic [2:0]      step_nx;
    logic            q_s, go, ph_settle, ph_pulse, mis;
    logic            d_nx, c_nx, r_nx;

    bist_sync2 u_sync (.C(C), .R(R), .d(dut_q), .q(q_s));

    assign go        = (state == IDLE || state == DONE) && start;
    assign ph_settle = ph == PH_W'(SETTLE - 1);
    assign ph_pulse  = ph == PH_W'(PULSE_W - 1);
    assign mis       = state == CHECK && q_s != STEP_TABLE[step].expect_q;
    assign busy      = state != IDLE && state != DONE;
    assign done      = state == DONE;
    assign pass      = done && fail_cnt == '0;

    always_ff @(posedge C or negedge R) begin
        if (!R) state <= IDLE;
        else    state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        step_nx  = step;
        case (state)
            IDLE, DONE: if (go) begin
                state_nx = SETUP;
                step_nx  = 3'd0;
            end
            SETUP: state_nx = ph_settle ? PULSE : SETUP;
            PULSE: state_nx = ph_pulse ? HOLD : PULSE;
            HOLD:  state_nx = ph_settle ? CHECK : HOLD;
            CHECK: begin
                state_nx = step == 3'(NUM_STEPS - 1) ? DONE : SETUP;
                step_nx  = step == 3'(NUM_STEPS - 1) ? step : step + 3'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Flop-under-test drives are computed for the upcoming state so they register in step with it
    always_comb begin
        d_nx = dut_d;
        c_nx = 1'b0;
        r_nx = 1'b1;
        case (state_nx)
            SETUP, HOLD, CHECK: begin
                d_nx = STEP_TABLE[step_nx].d;
                r_nx = STEP_TABLE[step_nx].r_setup;
            end
            PULSE: begin
                d_nx = STEP_TABLE[step_nx].d;
                c_nx = STEP_TABLE[step_nx].c_pulse;
                r_nx = STEP_TABLE[step_nx].r_setup | STEP_TABLE[step_nx].r_pulse;
            end
            DONE:    r_nx = 1'b0;
            default: d_nx = 1'b0;
        endcase
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            ph         <= '0;
            step       <= 3'd0;
            fail_cnt   <= '0;
            first_fail <= 3'd0;
            dut_d      <= 1'b0;
            dut_c      <= 1'b0;
            dut_r      <= 1'b1;
        end else begin
            ph    <= state_nx != state ? '0 : ph + 1'b1;
            step  <= step_nx;
            dut_d <= d_nx;
            dut_c <= c_nx;
            dut_r <= r_nx;
            if (go) begin
                fail_cnt   <= '0;
                first_fail <= 3'd0;
            end else if (mis) begin
                if (fail_cnt == '0) first_fail <= step;
                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end
endmodule
